mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-ported unified memory between the instruction-fetch path and the load/store path of the RV32I core. It sits between the core and a variable-latency memory that uses a req/ready handshake. It grants one transaction at a time with data-over-fetch priority plus an anti-starvation guard, and registers the winning request onto the memory port.

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one registered req/ready memory port with an anti-starvation guard.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY transactions that see no mem_ready within TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          we_q, we_d;
  logic          idle, sat, grant_d, grant_i, done, tmo;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  // tcnt_q is zero in the first BUSY cycle, so the abort lands in BUSY cycle TIMEOUT_CYCLES
  always_comb begin
    tmo    = state_q != IDLE && !mem_ready && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    tcnt_d = (state_q != IDLE) ? tcnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    idle     = state_q == IDLE;
    sat      = streak_q == SW'(STARVE_LIMIT);
    grant_d  = idle && d_req && !(if_req && sat && STARVE_LIMIT != 0);
    grant_i  = idle && if_req && !grant_d;
    done     = !idle && (mem_ready || tmo);
    state_d  = done ? IDLE : grant_d ? BUSY_D : grant_i ? BUSY_I : state_q;
    streak_d = grant_i ? '0 : (grant_d && if_req && !sat) ? streak_q + 1'b1 : streak_q;
    addr_d   = grant_d ? d_addr : grant_i ? if_addr : addr_q;
    we_d     = grant_d ? d_we : grant_i ? 1'b0 : we_q;
    wdata_d  = grant_d ? d_wdata : grant_i ? 32'h0 : wdata_q;
    wstrb_d  = grant_d ? d_wstrb : grant_i ? 4'h0 : wstrb_q;
    mem_req  = !idle;
    if_ack   = state_q == BUSY_I && done;
    d_ack    = state_q == BUSY_D && done;
    if_err   = if_ack && tmo;
    d_err    = d_ack && tmo;
    if_rdata = (if_ack && !tmo) ? mem_rdata : 32'h0;
    d_rdata  = (d_ack && !tmo) ? mem_rdata : 32'h0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; expected transactions are queued as requests
// are driven and checked in grant order against the memory-port fields and ack payload.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [137:0] all_out;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign all_out = {mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
                    if_ack, if_err, if_rdata, d_ack, d_err, d_rdata};

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0, lat = 1, wcnt = 0;
  bit tie_ready = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  // memory model: mem_ready after lat BUSY cycles (or always, when tied high)
  always @(negedge clk) begin
    if (tie_ready) mem_ready = 1'b1;
    else if (mem_req) begin
      wcnt++;
      mem_ready = wcnt >= lat;
    end else begin
      wcnt = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_ready ? mem_val(mem_addr) : 32'hBAD0_BAD0;
  end

  exp_t m_e;
  logic [136:0] m_got, m_want;
  always begin
    @(negedge clk); #2;
    if (if_ack || d_ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack if_ack=%0b d_ack=%0b required no ack", if_ack, d_ack);
      end else begin
        m_e = exp_q.pop_front();
        m_got = {if_ack, d_ack, mem_addr, mem_we, mem_wstrb,
                 (m_e.is_d && m_e.we) ? mem_wdata : 32'h0,
                 d_ack ? d_rdata : if_rdata, d_ack ? d_err : if_err,
                 d_ack ? if_rdata : d_rdata, d_ack ? if_err : d_err};
        m_want = {!m_e.is_d, m_e.is_d, m_e.addr, m_e.we, m_e.wstrb,
                  (m_e.is_d && m_e.we) ? m_e.wdata : 32'h0,
                  m_e.rdata, m_e.err, 32'h0, 1'b0};
        if (m_got !== m_want) begin
          miscompares++;
          $display("FAIL ack_payload got %h required %h", m_got, m_want);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {if_req, d_req, d_we} = '0;
    {if_addr, d_addr, d_wdata, d_wstrb} = '0;
    tie_ready = 1'b0;
    lat = 1;
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h required 0", all_out);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    int n;
    do_reset();
    lat = 2;
    exp_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0050_0093, 1'b0});
    if_addr = 32'h100;
    if_req = 1'b1;
    step();
    vectors++;
    if ({mem_req, mem_addr, mem_we, mem_wstrb} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL fetch_mem_port got req=%0b addr=%h we=%0b wstrb=%h required 1/100/0/0",
               mem_req, mem_addr, mem_we, mem_wstrb);
    end
    n = 1;
    while (!if_ack && n < 20) begin step(); n++; end
    vectors++;
    if (n !== 2 || !if_ack) begin
      miscompares++;
      $display("FAIL fetch_latency got %0d cycles required 2", n);
    end
    if_req = 1'b0;
    step();
    vectors++;
    if ({mem_req, if_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL fetch_ack_single got mem_req=%0b if_ack=%0b required 0/0", mem_req, if_ack);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    exp_q.push_back('{1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF, mem_val(32'h2000), 1'b0});
    exp_q.push_back('{1'b0, 32'h300, 1'b0, 32'h0, 4'h0, mem_val(32'h300), 1'b0});
    d_addr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    step();
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin
      miscompares++;
      $display("FAIL simul_data_first got req=%0b we=%0b addr=%h wdata=%h wstrb=%h required 1/1/2000/deadbeef/f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    n = 1;
    while (!d_ack && n < 20) begin step(); n++; end
    vectors++;
    if (d_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_d_ack got 0 required 1");
    end
    d_req = 1'b0;
    n = 0;
    while (!if_ack && n < 20) begin step(); n++; end
    vectors++;
    if (n !== 2 || !if_ack) begin
      miscompares++;
      $display("FAIL simul_fetch_after got %0d cycles required 2", n);
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    int n, nd;
    do_reset();
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{1'b1, 32'h3000, 1'b0, 32'h0, 4'h0, mem_val(32'h3000), 1'b0});
    exp_q.push_back('{1'b0, 32'h400, 1'b0, 32'h0, 4'h0, mem_val(32'h400), 1'b0});
    exp_q.push_back('{1'b1, 32'h3000, 1'b0, 32'h0, 4'h0, mem_val(32'h3000), 1'b0});
    d_addr = 32'h3000; d_req = 1'b1;
    if_addr = 32'h400; if_req = 1'b1;
    n = 0;
    nd = 0;
    while (!if_ack && n < 40) begin
      step();
      n++;
      if (d_ack) nd++;
    end
    vectors++;
    if (nd !== 4 || !if_ack) begin
      miscompares++;
      $display("FAIL starve_grants got %0d data grants before fetch required 4", nd);
    end
    n = 0;
    do begin step(); n++; end while (!(d_ack || if_ack) && n < 10);
    vectors++;
    if (d_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL streak_cleared got d_ack=%0b if_ack=%0b required data win", d_ack, if_ack);
    end
    d_req = 1'b0;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    tie_ready = 1'b1;
    exp_q.push_back('{1'b1, 32'h5000, 1'b1, 32'h0, 4'h3, mem_val(32'h5000), 1'b0});
    d_addr = 32'h5000; d_we = 1'b1; d_wdata = 32'h0; d_wstrb = 4'h3; d_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if ((if_ack || d_ack) !== (i % 2 == 1) || (!(if_ack || d_ack) && mem_req !== 1'b0)) begin
        miscompares++;
        $display("FAIL zero_wait_cycle%0d got ack=%0b mem_req=%0b required ack=%0b", i,
                 if_ack || d_ack, mem_req, i % 2 == 1);
      end
      if ((if_ack || d_ack) && i < 11) begin
        a = 32'(i * 4);
        if (d_ack) begin
          d_req = 1'b0;
          if_addr = 32'h600 + a;
          if_req = 1'b1;
          exp_q.push_back('{1'b0, 32'h600 + a, 1'b0, 32'h0, 4'h0, mem_val(32'h600 + a), 1'b0});
        end else begin
          if_req = 1'b0;
          d_addr = 32'h5000 + a;
          d_wdata = a;
          d_req = 1'b1;
          exp_q.push_back('{1'b1, 32'h5000 + a, 1'b1, a, 4'h3, mem_val(32'h5000 + a), 1'b0});
        end
      end else if (if_ack || d_ack) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
    tie_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    lat = 1000;
    exp_q.push_back('{1'b1, 32'h7000, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0});
    d_addr = 32'h7000; d_we = 1'b1; d_wdata = 32'h1234_5678; d_wstrb = 4'hF; d_req = 1'b1;
    step();
    step();
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_busy got mem_req=%0b required 1", mem_req);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got %h required 0", all_out);
    end
    exp_q.delete();
    {d_req, d_we} = '0;
    step();
    reset = 1'b1;
    lat = 1;
    exp_q.push_back('{1'b0, 32'h800, 1'b0, 32'h0, 4'h0, mem_val(32'h800), 1'b0});
    if_addr = 32'h800;
    if_req = 1'b1;
    n = 0;
    while (!if_ack && n < 20) begin step(); n++; end
    vectors++;
    if (n !== 1 || !if_ack) begin
      miscompares++;
      $display("FAIL reset_mid_recover got %0d cycles required 1", n);
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    lat = 1000;
    d_addr = 32'h9000; d_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_q.push_back('{1'b1, 32'h9000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1});
    n = 0;
    while (!d_ack && n < 20) begin step(); n++; end
    vectors++;
    if (n !== 8 || {d_ack, d_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL timeout_abort got cycle %0d ack=%0b err=%0b required 8/1/1", n, d_ack, d_err);
    end
    d_req = 1'b0;
    step();
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle got mem_req=%0b required 0", mem_req);
    end
`else
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (d_ack || d_err) n++;
    end
    vectors++;
    if (n !== 0 || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL no_timeout got %0d acks mem_req=%0b required 0/1", n, mem_req);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_zero_wait();
    test_reset_mid();
    test_timeout();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end
endmodule
